// File: rtl/alu_bist_pkg.sv
// -----------------------------------------------------------------------------
// alu_bist_pkg
// Shared types and helpers for the ALU BIST engine:
//   alu_op_e      ALU opcode encoding (0..7)
//   bist_state_e  sequencer state encoding
//   lfsr_taps()   Galois feedback masks for 16/32/64-bit registers
//                 (2*DATA_W for DATA_W = 8/16/32)
//   alu_golden()  reference ALU result, reduced modulo 2^width
// No ports (package).
// -----------------------------------------------------------------------------
package alu_bist_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_PASS = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_DONE    = 3'd4
  } bist_state_e;

  // Right-shifting Galois masks (maximal-length polynomials).
  // The x^0 term is always present, so the state never collapses to zero.
  localparam logic [63:0] TAPS_16 = 64'h0000_0000_0000_B400;
  localparam logic [63:0] TAPS_32 = 64'h0000_0000_8020_0003;
  localparam logic [63:0] TAPS_64 = 64'hD800_0000_0000_0000;

  function automatic logic [63:0] lfsr_taps(input int width);
    case (width)
      16:      return TAPS_16;
      32:      return TAPS_32;
      default: return TAPS_64;
    endcase
  endfunction

  // Golden result on a 32-bit container, masked down to the operand width.
  function automatic logic [31:0] alu_golden(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [2:0]  op,
                                             input int          width);
    logic [31:0] mask;
    logic [31:0] r;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    case (alu_op_e'(op))
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SHL:  r = a << 1;
      OP_SHR:  r = a >> 1;
      OP_PASS: r = a;
      default: r = '0;
    endcase
    return r & mask;
  endfunction

endpackage

// File: rtl/alu_bist_lfsr.sv
// -----------------------------------------------------------------------------
// alu_bist_lfsr
// Galois LFSR that supplies operand pairs to the BIST engine.
// Parameters: WIDTH (16/32/64), SEED (a zero seed is replaced by 1).
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset (state <= seed)
//   load     in   reload the seed
//   step     in   advance one LFSR step (load wins)
//   state    out  WIDTH  current LFSR contents
// -----------------------------------------------------------------------------
module alu_bist_lfsr
  import alu_bist_pkg::*;
#(
  parameter int          WIDTH = 16,
  parameter logic [63:0] SEED  = 64'd1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  localparam logic [63:0]      TAPS_ALL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_RAW = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED_RAW == '0) ? {{(WIDTH-1){1'b0}}, 1'b1}
                                                           : SEED_RAW;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SEED_EFF;
    end else if (load) begin
      state <= SEED_EFF;
    end else if (step) begin
      state <= {1'b0, state[WIDTH-1:1]} ^ (state[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/alu_bist_engine.sv
// -----------------------------------------------------------------------------
// alu_bist_engine
// Built-in self test for an external ALU. For each of NUM_PATTERNS
// pseudo-random operand pairs, every opcode 0..7 is applied, the ALU result
// is compared with a golden model, mismatches are counted and the first one
// is captured.
// Optional feature: define ALU_BIST_MISR_EN to add the misr_sig port and a
// MISR that folds {alu_result, golden} on every check.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   bist_start, bist_abort       control requests
//   alu_result  in  DATA_W       ALU output under test
//   a, b        out DATA_W       operands; opcode out 3
//   bist_busy/done/pass/fail     status
//   err_count   out 16           saturating mismatch count
//   ff_pattern/ff_opcode/ff_actual/ff_expected   first-failure capture
//   misr_sig    out 2*DATA_W     (ALU_BIST_MISR_EN only)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for bist_start; status of last run is held
// APPLY    | drive a/b from the LFSR, opcode already registered
// CHECK    | compare alu_result with golden, count/capture mismatch
// ADVANCE  | next opcode, or next pattern (LFSR step), or finish
// DONE     | publish done/pass, return to IDLE
// -----------------------------------------------------------------------------
module alu_bist_engine
  import alu_bist_pkg::*;
#(
  parameter int          DATA_W       = 8,
  parameter int          NUM_PATTERNS = 64,
  parameter logic [63:0] LFSR_SEED    = 64'd1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bist_start,
  input  logic              bist_abort,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [2:0]        opcode,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_pass,
  output logic              bist_fail,
  output logic [15:0]       err_count,
  output logic [15:0]       ff_pattern,
  output logic [2:0]        ff_opcode,
  output logic [DATA_W-1:0] ff_actual,
  output logic [DATA_W-1:0] ff_expected
`ifdef ALU_BIST_MISR_EN
  ,
  output logic [2*DATA_W-1:0] misr_sig
`endif
);

  localparam int          LW           = 2 * DATA_W;
  localparam logic [15:0] LAST_PATTERN = 16'(NUM_PATTERNS - 1);

  bist_state_e       state;
  logic [15:0]       pattern;
  logic [LW-1:0]     lfsr_q;
  logic [DATA_W-1:0] golden;
  logic              mismatch;
  logic              lfsr_load;
  logic              lfsr_step;
  logic              last_op;

  assign golden    = DATA_W'(alu_golden(32'(a), 32'(b), opcode, DATA_W));
  assign mismatch  = (alu_result != golden);
  assign last_op   = (opcode == 3'd7);

  // Abort wins over start even in IDLE so a simultaneous request does nothing.
  assign lfsr_load = (state == ST_IDLE) && bist_start && !bist_abort;
  assign lfsr_step = (state == ST_ADVANCE) && last_op && (pattern != LAST_PATTERN)
                     && !bist_abort;

  alu_bist_lfsr #(
    .WIDTH (LW),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (lfsr_load),
    .step    (lfsr_step),
    .state   (lfsr_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pattern     <= '0;
      a           <= '0;
      b           <= '0;
      opcode      <= '0;
      bist_busy   <= 1'b0;
      bist_done   <= 1'b0;
      bist_pass   <= 1'b0;
      bist_fail   <= 1'b0;
      err_count   <= '0;
      ff_pattern  <= '0;
      ff_opcode   <= '0;
      ff_actual   <= '0;
      ff_expected <= '0;
    end else if (bist_abort && (state != ST_IDLE)) begin
      // Counters and capture registers are intentionally left untouched.
      state     <= ST_IDLE;
      bist_busy <= 1'b0;
      bist_done <= 1'b0;
      bist_pass <= 1'b0;
      bist_fail <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lfsr_load) begin
            state       <= ST_APPLY;
            bist_busy   <= 1'b1;
            bist_done   <= 1'b0;
            bist_pass   <= 1'b0;
            bist_fail   <= 1'b0;
            err_count   <= '0;
            ff_pattern  <= '0;
            ff_opcode   <= '0;
            ff_actual   <= '0;
            ff_expected <= '0;
            pattern     <= '0;
            opcode      <= '0;
          end
        end

        ST_APPLY: begin
          a     <= lfsr_q[LW-1:DATA_W];
          b     <= lfsr_q[DATA_W-1:0];
          state <= ST_CHECK;
        end

        ST_CHECK: begin
          if (mismatch) begin
            bist_fail <= 1'b1;
            if (err_count != 16'hFFFF) begin
              err_count <= err_count + 16'd1;
            end
            // err_count saturates and never wraps, so zero marks "no failure yet".
            if (err_count == 16'd0) begin
              ff_pattern  <= pattern;
              ff_opcode   <= opcode;
              ff_actual   <= alu_result;
              ff_expected <= golden;
            end
          end
          state <= ST_ADVANCE;
        end

        ST_ADVANCE: begin
          if (!last_op) begin
            opcode <= opcode + 3'd1;
            state  <= ST_APPLY;
          end else if (pattern != LAST_PATTERN) begin
            pattern <= pattern + 16'd1;
            opcode  <= '0;
            state   <= ST_APPLY;
          end else begin
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          bist_done <= 1'b1;
          bist_pass <= ~bist_fail;
          bist_busy <= 1'b0;
          state     <= ST_IDLE;
        end

        default: begin
          state     <= ST_IDLE;
          bist_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_BIST_MISR_EN
  localparam logic [63:0]   MISR_TAPS_ALL = lfsr_taps(LW);
  localparam logic [LW-1:0] MISR_TAPS     = MISR_TAPS_ALL[LW-1:0];

  logic [LW-1:0] misr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misr_q <= '0;
    end else if (lfsr_load) begin
      misr_q <= '0;
    end else if ((state == ST_CHECK) && !bist_abort) begin
      misr_q <= {1'b0, misr_q[LW-1:1]} ^ (misr_q[0] ? MISR_TAPS : '0)
                ^ {alu_result, golden};
    end
  end

  assign misr_sig = misr_q;
`endif

endmodule

// File: tb/tb_alu_bist_engine.sv
// -----------------------------------------------------------------------------
// tb_alu_bist_engine
// Self-checking bench for alu_bist_engine (DATA_W=8, NUM_PATTERNS=4).
// The bench owns a behavioural ALU whose faults are described by a per
// pattern/opcode XOR table (or a stuck-at-zero switch); the expected BIST
// outcome is computed from the same fault description with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_bist_engine;

  localparam int DW      = 8;
  localparam int NP      = 4;
  localparam int LATENCY = 3 * 8 * NP + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          bist_start;
  logic          bist_abort;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] a, b;
  logic [2:0]    opcode;
  logic          bist_busy, bist_done, bist_pass, bist_fail;
  logic [15:0]   err_count, ff_pattern;
  logic [2:0]    ff_opcode;
  logic [DW-1:0] ff_actual, ff_expected;
`ifdef ALU_BIST_MISR_EN
  logic [2*DW-1:0] misr_sig;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_bist_engine #(
    .DATA_W       (DW),
    .NUM_PATTERNS (NP),
    .LFSR_SEED    (64'd1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bist_start  (bist_start),
    .bist_abort  (bist_abort),
    .alu_result  (alu_result),
    .a           (a),
    .b           (b),
    .opcode      (opcode),
    .bist_busy   (bist_busy),
    .bist_done   (bist_done),
    .bist_pass   (bist_pass),
    .bist_fail   (bist_fail),
    .err_count   (err_count),
    .ff_pattern  (ff_pattern),
    .ff_opcode   (ff_opcode),
    .ff_actual   (ff_actual),
    .ff_expected (ff_expected)
`ifdef ALU_BIST_MISR_EN
    ,
    .misr_sig    (misr_sig)
`endif
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] pat_a [NP];
  logic [DW-1:0] pat_b [NP];
  logic [DW-1:0] fmask [NP][8];
  bit            stuck0 = 1'b0;

  function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                            input int op);
    int unsigned m;
    int unsigned xv;
    int unsigned yv;
    int unsigned r;
    m  = 32'd1 << DW;
    xv = 32'(x);
    yv = 32'(y);
    case (op)
      0:       r = (xv + yv) % m;
      1:       r = (xv + m - yv) % m;
      2:       r = xv & yv;
      3:       r = xv | yv;
      4:       r = xv ^ yv;
      5:       r = (xv * 2) % m;
      6:       r = xv / 2;
      default: r = xv;
    endcase
    return DW'(r);
  endfunction

  // Behavioural ALU under test: golden result with injected faults.
  function automatic logic [DW-1:0] model_alu(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                              input int op);
    logic [DW-1:0] g;
    g = ref_alu(x, y, op);
    if (stuck0) return '0;
    for (int p = 0; p < NP; p++) begin
      if (pat_a[p] == x && pat_b[p] == y) return g ^ fmask[p][op];
    end
    return g;
  endfunction

  // Operand pairs: 16-bit Galois sequence x^16+x^14+x^13+x^11+1 from seed 1.
  task automatic build_patterns();
    logic [15:0] s;
    s = 16'h0001;
    for (int p = 0; p < NP; p++) begin
      pat_a[p] = s[15:8];
      pat_b[p] = s[7:0];
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    end
  endtask

  task automatic clear_faults();
    stuck0 = 1'b0;
    for (int p = 0; p < NP; p++)
      for (int o = 0; o < 8; o++) fmask[p][o] = '0;
  endtask

  always @(negedge clk) alu_result = model_alu(a, b, int'(opcode));

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_val({tag, "_a"},      32'(a), 0);
    check_val({tag, "_b"},      32'(b), 0);
    check_val({tag, "_op"},     32'(opcode), 0);
    check_val({tag, "_status"}, {28'd0, bist_busy, bist_done, bist_pass, bist_fail}, 0);
    check_val({tag, "_err"},    32'(err_count), 0);
    check_val({tag, "_ff"},     {13'd0, ff_opcode, ff_pattern} | 32'({ff_actual, ff_expected}), 0);
  endtask

  // Full run from the fault description: every pattern x opcode.
  task automatic check_run(input string tag, input int lat);
    int            e_err;
    int            e_fp;
    int            e_fo;
    logic [DW-1:0] e_act;
    logic [DW-1:0] e_exp;
    logic [DW-1:0] act;
    logic [DW-1:0] g;
    e_err = 0; e_fp = 0; e_fo = 0; e_act = '0; e_exp = '0;
    for (int p = 0; p < NP; p++) begin
      for (int o = 0; o < 8; o++) begin
        g   = ref_alu(pat_a[p], pat_b[p], o);
        act = model_alu(pat_a[p], pat_b[p], o);
        if (act != g) begin
          if (e_err == 0) begin
            e_fp = p; e_fo = o; e_act = act; e_exp = g;
          end
          e_err++;
        end
      end
    end
    check_val({tag, "_latency"}, 32'(lat), LATENCY);
    check_val({tag, "_done"},    32'(bist_done), 1);
    check_val({tag, "_pass"},    32'(bist_pass), (e_err == 0) ? 1 : 0);
    check_val({tag, "_fail"},    32'(bist_fail), (e_err == 0) ? 0 : 1);
    check_val({tag, "_busy"},    32'(bist_busy), 0);
    check_val({tag, "_err"},     32'(err_count), 32'(e_err));
    check_val({tag, "_ffpat"},   32'(ff_pattern), 32'(e_fp));
    check_val({tag, "_ffop"},    32'(ff_opcode), 32'(e_fo));
    check_val({tag, "_ffact"},   32'(ff_actual), 32'(e_act));
    check_val({tag, "_ffexp"},   32'(ff_expected), 32'(e_exp));
  endtask

  // Start pulse sampled at edge 0; lat counts edges after that one.
  // restart_at / abort_at: edge at which a second start / an abort is sampled.
  task automatic run_bist(input int restart_at, input int abort_at, input int reset_at,
                          output int lat);
    @(negedge clk);
    bist_start = 1'b1;
    @(posedge clk);
    #1;
    bist_start = 1'b0;
    check_val("busy_after_start", 32'(bist_busy), 1);
    check_val("done_after_start", 32'(bist_done), 0);
    lat = 0;
    while (!bist_done && lat < 2 * LATENCY) begin
      @(posedge clk);
      #1;
      lat++;
      if (abort_at > 0 && lat == abort_at) break;
      if (reset_at > 0 && lat == reset_at) break;
      bist_start = (lat + 1 == restart_at);
      bist_abort = (lat + 1 == abort_at);
    end
    bist_start = 1'b0;
    bist_abort = 1'b0;
    if (lat >= 2 * LATENCY) check_val("run_timeout", 32'(lat), LATENCY);
  endtask

  // ---------------- stimulus ----------------
  int lat;

  initial begin
    reset_n    = 1'b0;
    bist_start = 1'b0;
    bist_abort = 1'b0;
    alu_result = '0;
    build_patterns();
    clear_faults();
    #12;
    check_idle_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Clean run.
    run_bist(0, 0, 0, lat);
    check_run("clean", lat);

    // Corrupt opcode 1 on pattern 2.
    clear_faults();
    fmask[2][1] = 8'h10;
    run_bist(0, 0, 0, lat);
    check_run("sub_p2", lat);
    check_val("sub_p2_ffexp_direct", 32'(ff_expected), 32'(DW'(pat_a[2] - pat_b[2])));

    // Stuck-at-zero ALU.
    clear_faults();
    stuck0 = 1'b1;
    run_bist(0, 0, 0, lat);
    check_run("stuck0", lat);

    // Randomized fault sets.
    for (int it = 0; it < 6; it++) begin
      clear_faults();
      for (int k = 0; k < int'($urandom_range(1, 3)); k++)
        fmask[$urandom_range(0, NP - 1)][$urandom_range(0, 7)] = DW'($urandom_range(1, 255));
      run_bist(0, 0, 0, lat);
      check_run("random", lat);
    end

    // Reset mid-run (stuck ALU so counters are nonzero before reset).
    clear_faults();
    stuck0 = 1'b1;
    run_bist(0, 0, 30, lat);
    check_val("pre_reset_err_nonzero", 32'(err_count != 0), 1);
    reset_n = 1'b0;
    #1;
    check_idle_zero("midrun_reset");
    @(negedge clk);
    reset_n = 1'b1;
    clear_faults();
    run_bist(0, 0, 0, lat);
    check_run("after_reset", lat);

    // Start while busy is ignored: completion still measured from first start.
    run_bist(5, 0, 0, lat);
    check_run("restart_ignored", lat);

    // Abort at edge 10 with a fault on pattern 0 opcode 0 already counted.
    clear_faults();
    fmask[0][0] = 8'h01;
    run_bist(0, 10, 0, lat);
    check_val("abort_edge", 32'(lat), 10);
    check_val("abort_status", {28'd0, bist_busy, bist_done, bist_pass, bist_fail}, 0);
    check_val("abort_err_held", 32'(err_count), 1);
    check_val("abort_ffop_held", 32'(ff_opcode), 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("abort_stays_idle", 32'(bist_busy), 0);
    clear_faults();
    run_bist(0, 0, 0, lat);
    check_run("after_abort", lat);

`ifdef ALU_BIST_MISR_EN
    begin
      logic [2*DW-1:0] sig1;
      logic [2*DW-1:0] sig2;
      run_bist(0, 0, 0, lat);
      sig1 = misr_sig;
      run_bist(0, 0, 0, lat);
      sig2 = misr_sig;
      check_val("misr_repeat_equal", 32'(sig1 == sig2), 1);
      fmask[1][3] = 8'h04;
      run_bist(0, 0, 0, lat);
      check_val("misr_fault_differs", 32'(misr_sig != sig1), 1);
      clear_faults();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_bist_engine.md
ALU_BIST_ENGINE -- requirements
Module: alu_bist_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, ALU operand/result width; legal values 8, 16, 32.
REQ-002 SHALL have parameter NUM_PATTERNS, default 64, number of pseudo-random operand pairs (1..65535).
REQ-003 SHALL have parameter LFSR_SEED, default 1, 2*DATA_W-bit initial LFSR state; a zero seed SHALL be replaced by 1.
REQ-004 Ports: clk  in  1  sole clock; reset_n  in  1  asynchronous active-low reset.
REQ-005 Ports: bist_start  in  1  start request; bist_abort  in  1  abort request.
REQ-006 Ports: alu_result  in  DATA_W  ALU output under test; a, b  out  DATA_W  operands; opcode  out  3  ALU operation.
REQ-007 Ports: bist_busy, bist_done, bist_pass, bist_fail  out  1  status.
REQ-008 Ports: err_count  out  16  mismatch count; ff_pattern  out  16, ff_opcode  out  3, ff_actual  out  DATA_W, ff_expected  out  DATA_W  first-failure capture.

Function
REQ-009 FSM states SHALL be IDLE, APPLY, CHECK, ADVANCE, DONE.
REQ-010 IDLE: bist_start=1 SHALL clear err_count, sticky fail and the capture registers, load LFSR_SEED, set pattern=0, opcode=0, and go to APPLY.
REQ-011 APPLY: a=LFSR[2*DATA_W-1:DATA_W], b=LFSR[DATA_W-1:0], opcode registered; next state CHECK.
REQ-012 CHECK: alu_result SHALL be compared with the internal golden result for the registered a, b, opcode; next state ADVANCE.
REQ-013 Golden ops, all mod 2^DATA_W: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 a<<1 zero-fill, 6 a>>1 zero-fill, 7 pass a.
REQ-014 On mismatch: err_count +1, saturating at 16'hFFFF; bist_fail set sticky.
REQ-015 On the first mismatch only, ff_pattern, ff_opcode, ff_actual and ff_expected SHALL be captured.
REQ-016 ADVANCE, opcode<7: opcode+1, go to APPLY.
REQ-017 ADVANCE, opcode==7 and pattern<NUM_PATTERNS-1: LFSR steps once, pattern+1, opcode=0, go to APPLY.
REQ-018 ADVANCE, opcode==7 and pattern==NUM_PATTERNS-1: go to DONE.
REQ-019 Every opcode of every pattern SHALL be checked, including after the first failure; there is no early exit.
REQ-020 DONE: bist_done=1, bist_pass=~fail; next state IDLE.
REQ-021 bist_done, bist_pass and bist_fail SHALL hold until the next accepted start.
REQ-022 Latency: bist_done rises on the (3*8*NUM_PATTERNS+1)th rising edge after the edge that samples bist_start.
REQ-023 bist_busy=1 in every state except IDLE.
REQ-024 bist_start SHALL be ignored while busy.
REQ-025 bist_abort has priority over bist_start and completion: in any busy state it forces IDLE next edge with done=0, pass=0, fail=0; counters and capture values are held.
REQ-026 LFSR: Galois, 2*DATA_W bits, taps per DATA_W from the package table; it SHALL never reach zero.

Reset
REQ-027 reset_n=0 SHALL asynchronously force IDLE, LFSR=seed, all outputs 0 (a, b, opcode, status, err_count, capture), including mid-run.

Configuration
REQ-028 With ALU_BIST_MISR_EN defined: port misr_sig out 2*DATA_W; every CHECK folds {alu_result, golden} into a MISR cleared at start; value held after DONE.
REQ-029 Without ALU_BIST_MISR_EN: no misr_sig port and no MISR logic.

Structure
REQ-030 Package alu_bist_pkg SHALL hold the opcode enum, the FSM state enum, the LFSR tap table for 8/16/32 and the golden-result function.
REQ-031 Sub-module alu_bist_lfsr (parameter WIDTH, SEED; load and step inputs) SHALL generate operands.

Verification
REQ-032 DATA_W=8, NUM_PATTERNS=4, correct ALU model, start pulse -> done at edge 97, pass=1, fail=0, err_count=0.
REQ-033 Same configuration, ALU model corrupts opcode 1 on pattern 2 -> fail=1, err_count=1, ff_pattern=2, ff_opcode=1, ff_expected=a-b.
REQ-034 ALU model with result stuck at 0 on every op, NUM_PATTERNS=4 -> err_count = number of nonzero golden results, ff_pattern=0.
REQ-035 reset_n pulled low at edge 30 of a run -> all outputs 0 immediately; a new start afterwards yields the REQ-032 result.
REQ-036 bist_abort at edge 10, then bist_start asserted while busy -> idle, done=0; the start while busy is ignored; a later start completes normally.
REQ-037 ALU_BIST_MISR_EN defined with two identical passing runs -> equal misr_sig; with a single-bit fault -> different misr_sig.
